// File: rtl/array_writer.sv
// Register file of NUM_INP entries exposed as one flat packed vector.
// Written by single indexed beats or by auto-incrementing fill bursts over a valid/ready port.
module array_writer #(
  parameter int DW      = 32,
  parameter int NUM_INP = 8,
  parameter int LW      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [4:0]            wr_idx,
  input  logic [DW-1:0]         wr_data,
  input  logic                  fill_start,
  input  logic [4:0]            fill_base,
  input  logic [LW-1:0]         fill_len,
  output logic [NUM_INP*DW-1:0] outs,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  dbg_state
);

  // Handshake: a beat transfers on a rising edge where wr_vld && wr_rdy; wr_vld must
  // hold with stable data until then. wr_rdy is low during clr and while a burst is being started.

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  localparam logic [5:0] NUM6 = 6'(NUM_INP);
  localparam logic [4:0] LAST = 5'(NUM_INP - 1);

  state_t            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     mem_q [NUM_INP];
  logic [DW-1:0]     mem_d [NUM_INP];
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_INP; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int k = 0; k < NUM_INP; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (fill_start && (fill_len != '0)) state_d = S_FILL;
        S_FILL: if (accept && (cnt_q == LW'(1))) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_rdy    = !clr && (((state_q == S_IDLE) && !fill_start) || (state_q == S_FILL));
    busy      = (state_q == S_FILL);
    done      = done_q;
    err       = err_q;
    dbg_state = state_q;
    for (int k = 0; k < NUM_INP; k++) outs[k*DW +: DW] = mem_q[k];
  end

  assign accept = wr_vld && wr_rdy;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    for (int k = 0; k < NUM_INP; k++) mem_d[k] = mem_q[k];
    if (clr) begin
      ptr_d = '0;
      cnt_d = '0;
      for (int k = 0; k < NUM_INP; k++) mem_d[k] = '0;
    end else if (state_q == S_IDLE) begin
      if (fill_start) begin
        ptr_d  = 5'({1'b0, fill_base} % NUM6);
        cnt_d  = fill_len;
        done_d = (fill_len == '0);
      end else if (accept) begin
        if ({1'b0, wr_idx} < NUM6) begin
          for (int k = 0; k < NUM_INP; k++)
            if (wr_idx == 5'(k)) mem_d[k] = wr_data;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < NUM_INP; k++)
        if (ptr_q == 5'(k)) mem_d[k] = wr_data;
      ptr_d  = (ptr_q == LAST) ? 5'd0 : ptr_q + 5'd1;
      cnt_d  = cnt_q - LW'(1);
      done_d = (cnt_q == LW'(1));
    end
  end

endmodule

// File: tb/tb_array_writer.sv
// Directed bench for array_writer: single writes, range errors, wrapping bursts,
// zero-length bursts, start/write collision, clear and asynchronous reset mid-burst.
module tb_array_writer;

  localparam int DW      = 32;
  localparam int NUM_INP = 8;
  localparam int LW      = 6;
  localparam int VW      = NUM_INP * DW;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              wr_vld;
  logic              wr_rdy;
  logic [4:0]        wr_idx;
  logic [DW-1:0]     wr_data;
  logic              fill_start;
  logic [4:0]        fill_base;
  logic [LW-1:0]     fill_len;
  logic [VW-1:0]     outs;
  logic              busy;
  logic              done;
  logic              err;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [NUM_INP];

  array_writer #(.DW(DW), .NUM_INP(NUM_INP), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .wr_vld     (wr_vld),
    .wr_rdy     (wr_rdy),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_len   (fill_len),
    .outs       (outs),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_outs();
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_INP; k++) v[k*DW +: DW] = exp_mem[k];
    return v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NUM_INP; k++) exp_mem[k] = '0;
  endtask

  // driver tasks: drive after falling edge, sample 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_write(input logic [4:0] idx, input logic [DW-1:0] data);
    @(negedge clk);
    wr_vld  = 1'b1;
    wr_idx  = idx;
    wr_data = data;
    tick();
    wr_vld  = 1'b0;
  endtask

  task automatic start_fill(input logic [4:0] base, input logic [LW-1:0] len);
    @(negedge clk);
    fill_start = 1'b1;
    fill_base  = base;
    fill_len   = len;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic fill_beat(input logic [DW-1:0] data);
    @(negedge clk);
    wr_vld  = 1'b1;
    wr_data = data;
    tick();
    wr_vld  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_vld = 1'b0; wr_idx = '0; wr_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_outs", outs, '0);
    check("reset_busy", VW'(busy), '0);
    check("reset_done", VW'(done), '0);
    check("reset_err", VW'(err), '0);
    check("reset_state", VW'(dbg_state), '0);
    check("reset_rdy", VW'(wr_rdy), VW'(1));

    // single writes
    single_write(5'd3, 32'hA5A5A5A5);
    exp_mem[3] = 32'hA5A5A5A5;
    check("single_idx3", outs, exp_outs());
    check("single_idx3_slice", VW'(outs[127:96]), VW'(32'hA5A5A5A5));
    single_write(5'd0, 32'h1);
    exp_mem[0] = 32'h1;
    check("single_idx0", outs, exp_outs());
    check("single_err0", VW'(err), '0);

    // out-of-range index
    single_write(5'd9, 32'hFF);
    check("oor_outs", outs, exp_outs());
    check("oor_err_pulse", VW'(err), VW'(1));
    tick();
    check("oor_err_clear", VW'(err), '0);

    // wrapping burst with a stall between beats 2 and 3
    start_fill(5'd6, 6'd4);
    check("fill_busy_start", VW'(busy), VW'(1));
    fill_beat(32'h10);
    fill_beat(32'h11);
    tick();
    check("fill_busy_stall", VW'(busy), VW'(1));
    check("fill_stall_done", VW'(done), '0);
    fill_beat(32'h12);
    check("fill_busy_b3", VW'(busy), VW'(1));
    fill_beat(32'h13);
    exp_mem[6] = 32'h10; exp_mem[7] = 32'h11; exp_mem[0] = 32'h12; exp_mem[1] = 32'h13;
    check("fill_outs", outs, exp_outs());
    check("fill_done", VW'(done), VW'(1));
    check("fill_busy_end", VW'(busy), '0);
    tick();
    check("fill_done_clear", VW'(done), '0);

    // zero-length burst
    start_fill(5'd2, 6'd0);
    check("zero_done", VW'(done), VW'(1));
    check("zero_busy", VW'(busy), '0);
    check("zero_outs", outs, exp_outs());
    tick();
    check("zero_done_clear", VW'(done), '0);

    // start/write collision: held beat becomes burst beat 1
    @(negedge clk);
    fill_start = 1'b1; fill_base = 5'd2; fill_len = 6'd1;
    wr_vld = 1'b1; wr_idx = 5'd5; wr_data = 32'h77;
    #1;
    check("collide_rdy", VW'(wr_rdy), '0);
    tick();
    check("collide_outs_hold", outs, exp_outs());
    check("collide_busy", VW'(busy), VW'(1));
    @(negedge clk);
    fill_start = 1'b0;
    #1;
    check("collide_rdy_fill", VW'(wr_rdy), VW'(1));
    tick();
    wr_vld = 1'b0;
    exp_mem[2] = 32'h77;
    check("collide_outs", outs, exp_outs());
    check("collide_done", VW'(done), VW'(1));

    // clear during burst
    start_fill(5'd0, 6'd8);
    fill_beat(32'h20);
    fill_beat(32'h21);
    fill_beat(32'h22);
    @(negedge clk);
    clr = 1'b1; wr_vld = 1'b1; wr_data = 32'h99;
    #1;
    check("clr_rdy", VW'(wr_rdy), '0);
    tick();
    clr = 1'b0; wr_vld = 1'b0;
    clear_model();
    check("clr_outs", outs, '0);
    check("clr_busy", VW'(busy), '0);
    check("clr_done", VW'(done), '0);
    tick();
    check("clr_done_later", VW'(done), '0);
    single_write(5'd2, 32'h55);
    exp_mem[2] = 32'h55;
    check("post_clr_write", outs, exp_outs());

    // async reset mid-burst, released before the next rising edge
    start_fill(5'd1, 6'd5);
    fill_beat(32'h31);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", outs, '0);
    check("arst_busy", VW'(busy), '0);
    check("arst_done", VW'(done), '0);
    check("arst_err", VW'(err), '0);
    #1 rst_n = 1'b1;
    clear_model();
    start_fill(5'd3, 6'd1);
    check("arst_refill_busy", VW'(busy), VW'(1));
    fill_beat(32'hAB);
    exp_mem[3] = 32'hAB;
    check("arst_refill_outs", outs, exp_outs());
    check("arst_refill_done", VW'(done), VW'(1));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_writer.md
Name: array_writer

Overview:
- Write-side counterpart of the packed-array element selector. Holds NUM_INP entries of DW bits and presents them as one flat packed vector for downstream combinational readers.
- Entry k occupies bits [k*DW +: DW] of the vector.
- Updates come through a valid/ready write port, in one of two modes: single indexed writes, or auto-incrementing fill bursts.

Parameters:
- DW, 32, entry width in bits.
- NUM_INP, 8, number of entries (1..32).
- LW, 6, width of the burst-length field.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of all entries; aborts any burst.
- wr_vld  input  1  write beat valid.
- wr_rdy  output  1  write beat ready (combinational).
- wr_idx  input  5  target entry for single writes; ignored in FILL.
- wr_data  input  DW  write data.
- fill_start  input  1  start a burst; sampled in IDLE only.
- fill_base  input  5  first entry of the burst.
- fill_len  input  LW  number of beats in the burst.
- outs  output  NUM_INP*DW  packed entry array, registered.
- busy  output  1  high while in FILL.
- done  output  1  one-cycle pulse when a burst completes.
- err  output  1  one-cycle pulse when a single write has an out-of-range index.

Behaviour:
- Reset (rst_n low, asynchronous): outs=0, state=IDLE, ptr=0, cnt=0, busy=0, done=0, err=0.
- A beat is accepted when wr_vld && wr_rdy at a rising edge. The target entry updates at that edge and is visible on outs the next cycle (1-cycle latency). All other entries hold.
- wr_rdy = !clr && ((state==IDLE && !fill_start) || state==FILL).
- States: IDLE and FILL.
- IDLE, single write:
  - On acceptance with wr_idx < NUM_INP: entry[wr_idx] <= wr_data.
  - On acceptance with wr_idx >= NUM_INP: no entry changes; err pulses high the next cycle.
- IDLE, burst start:
  - fill_start && !clr: ptr <= fill_base mod NUM_INP, cnt <= fill_len.
  - If fill_len==0: stay IDLE; done pulses the next cycle; no writes occur.
  - Otherwise: go to FILL; busy=1 from the next cycle.
- FILL:
  - Each accepted beat writes entry[ptr] <= wr_data and decrements cnt.
  - ptr increments and wraps from NUM_INP-1 to 0.
  - fill_start is ignored; wr_idx is ignored; err never asserts.
  - Cycles with wr_vld low are stalls; state holds.
- Burst completion: the beat that brings cnt to 0 is the last write. On the following cycle: state=IDLE, busy=0, done=1 for exactly one cycle.
- Bursts longer than NUM_INP overwrite entries cyclically. The last value written to an entry wins.
- clr (highest priority):
  - All entries go to 0 at the edge; any concurrent beat is not accepted (wr_rdy=0).
  - If in FILL: go to IDLE, busy=0, cnt=0, no done pulse.
  - fill_start in the same cycle is ignored.
- Simultaneous fill_start and wr_vld in IDLE: the burst starts; the single-write beat is not accepted (wr_rdy=0). The producer must hold the beat.
- Reset asserted mid-burst: immediate return to the reset state; partial writes are discarded because outs is cleared.
- done and err are registered outputs; they never assert in the same cycle.

Test Plan:
- Single writes: after reset, write idx=3 data=0xA5A5A5A5, then idx=0 data=0x1 -> outs[127:96]=0xA5A5A5A5 and outs[31:0]=0x1 one cycle after each beat; all other bits 0; err=0.
- Out-of-range write: idx=9 data=0xFF with NUM_INP=8 -> outs unchanged; err=1 for exactly one cycle.
- Wrapping burst: fill_base=6, fill_len=4, data 0x10, 0x11, 0x12, 0x13 with one stall cycle between beats 2 and 3 -> entries 6,7,0,1 = 0x10,0x11,0x12,0x13; busy high throughout; done pulses one cycle after the 4th beat.
- Zero-length burst and start/write collision:
  - fill_len=0 -> done pulses next cycle, busy stays 0, outs unchanged.
  - fill_start together with wr_vld -> wr_rdy=0 in that cycle; the held beat is consumed as burst beat 1.
- Clear during burst: fill_base=0, fill_len=8, clr asserted after 3 beats -> outs=0, busy=0, no done, wr_rdy=0 in the clr cycle; a following single write to idx=2 succeeds.
- Async reset mid-burst: rst_n pulsed low for a fraction of a cycle during FILL -> outs, busy, done and err go to 0 immediately without waiting for a clock edge; the next fill_start behaves as from fresh reset.
